// File: rtl/prop_monitor.sv
// Multi-channel runtime property checker: per-channel ALWAYS / ONCE / ROSE evaluation
// with registered verdict pulses, saturating counters, sticky flags and first-failure capture.
module prop_monitor #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIN_W = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TS_W  = 32,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [2*NCH-1:0]       mode,
  input  logic [WIN_W*NCH-1:0]   win,
  input  logic [NCH-1:0]         trig,
  input  logic [NCH-1:0]         cond,
  output logic [NCH-1:0]         pass_pulse,
  output logic [NCH-1:0]         fail_pulse,
  output logic [NCH-1:0]         fail_sticky,
  output logic [CNT_W*NCH-1:0]   pass_cnt,
  output logic [CNT_W*NCH-1:0]   fail_cnt,
  output logic [TS_W-1:0]        ts,
  output logic                   first_fail_valid,
  output logic [CH_W-1:0]        first_fail_ch,
  output logic [TS_W-1:0]        first_fail_ts
);

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_ALWAYS = 2'd1;
  localparam logic [1:0] M_ONCE   = 2'd2;
  localparam logic [1:0] M_ROSE   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rose_st_e;

  rose_st_e          st     [NCH];
  logic [WIN_W-1:0]  wc     [NCH];
  logic [WIN_W-1:0]  win_q  [NCH];
  logic [NCH-1:0]    trig_q;
  logic [NCH-1:0]    once_done;

  logic [NCH-1:0]    rise_c;
  logic [NCH-1:0]    pass_c;
  logic [NCH-1:0]    fail_c;
  logic [CH_W-1:0]   ff_ch_c;

  // Verdict decode for the current sample, one pair of bits per channel.
  always_comb begin
    rise_c  = trig & ~trig_q;
    pass_c  = '0;
    fail_c  = '0;
    ff_ch_c = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode[2*i +: 2])
        M_ALWAYS: begin
          pass_c[i] = cond[i];
          fail_c[i] = ~cond[i];
        end
        M_ONCE: begin
          if (!once_done[i]) begin
            pass_c[i] = cond[i];
            fail_c[i] = ~cond[i];
          end
        end
        M_ROSE: begin
          if (st[i] == ST_IDLE) begin
            if (rise_c[i]) begin
              if (cond[i]) begin
                pass_c[i] = 1'b1;
              end else if (win[WIN_W*i +: WIN_W] == '0) begin
                fail_c[i] = 1'b1;
              end
            end
          end else begin
            if (cond[i]) begin
              pass_c[i] = 1'b1;
            end else if (wc[i] == win_q[i]) begin
              fail_c[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // Descending scan leaves the lowest failing index.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fail_c[i]) begin
        ff_ch_c = CH_W'(i);
      end
    end
  end

  // State, counters and reporting registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts               <= '0;
      trig_q           <= '0;
      once_done        <= '0;
      pass_pulse       <= '0;
      fail_pulse       <= '0;
      fail_sticky      <= '0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_ch    <= '0;
      first_fail_ts    <= '0;
      for (int i = 0; i < NCH; i++) begin
        st[i]    <= ST_IDLE;
        wc[i]    <= '0;
        win_q[i] <= '0;
      end
    end else begin
      ts     <= ts + TS_W'(1);
      trig_q <= trig;
      if (clear) begin
        once_done        <= '0;
        pass_pulse       <= '0;
        fail_pulse       <= '0;
        fail_sticky      <= '0;
        pass_cnt         <= '0;
        fail_cnt         <= '0;
        first_fail_valid <= 1'b0;
        first_fail_ch    <= '0;
        first_fail_ts    <= '0;
        for (int i = 0; i < NCH; i++) begin
          st[i] <= ST_IDLE;
          wc[i] <= '0;
        end
      end else begin
        pass_pulse  <= pass_c;
        fail_pulse  <= fail_c;
        fail_sticky <= fail_sticky | fail_c;
        if (!first_fail_valid && (|fail_c)) begin
          first_fail_valid <= 1'b1;
          first_fail_ch    <= ff_ch_c;
          first_fail_ts    <= ts;
        end
        for (int i = 0; i < NCH; i++) begin
          if (pass_c[i] && (pass_cnt[CNT_W*i +: CNT_W] != '1)) begin
            pass_cnt[CNT_W*i +: CNT_W] <= pass_cnt[CNT_W*i +: CNT_W] + CNT_W'(1);
          end
          if (fail_c[i] && (fail_cnt[CNT_W*i +: CNT_W] != '1)) begin
            fail_cnt[CNT_W*i +: CNT_W] <= fail_cnt[CNT_W*i +: CNT_W] + CNT_W'(1);
          end
          if (mode[2*i +: 2] == M_ONCE) begin
            once_done[i] <= 1'b1;
          end
          // Leaving ROSE drops any pending window silently.
          if (mode[2*i +: 2] != M_ROSE) begin
            st[i] <= ST_IDLE;
          end else begin
            case (st[i])
              ST_IDLE: begin
                if (rise_c[i] && !cond[i] && (win[WIN_W*i +: WIN_W] != '0)) begin
                  st[i]    <= ST_WAIT;
                  wc[i]    <= WIN_W'(1);
                  win_q[i] <= win[WIN_W*i +: WIN_W];
                end
              end
              ST_WAIT: begin
                if (cond[i] || (wc[i] == win_q[i])) begin
                  st[i] <= ST_IDLE;
                end else begin
                  wc[i] <= wc[i] + WIN_W'(1);
                end
              end
              default: st[i] <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prop_monitor.sv
// Bench for prop_monitor: directed scenarios plus random traffic, all checked against
// a cycle-level reference model built from deadlines and flags.
module tb_prop_monitor;

  localparam int unsigned NCH   = 4;
  localparam int unsigned WIN_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TS_W  = 32;
  localparam int unsigned CH_W  = 2;
  localparam int          CMAX  = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic [2*NCH-1:0]     mode = '0;
  logic [WIN_W*NCH-1:0] win = '0;
  logic [NCH-1:0]       trig = '0;
  logic [NCH-1:0]       cond = '0;
  logic [NCH-1:0]       pass_pulse, fail_pulse, fail_sticky;
  logic [CNT_W*NCH-1:0] pass_cnt, fail_cnt;
  logic [TS_W-1:0]      ts, first_fail_ts;
  logic                 first_fail_valid;
  logic [CH_W-1:0]      first_fail_ch;

  prop_monitor #(.NCH(NCH), .WIN_W(WIN_W), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .win(win),
    .trig(trig), .cond(cond), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
    .fail_sticky(fail_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .ts(ts),
    .first_fail_valid(first_fail_valid), .first_fail_ch(first_fail_ch),
    .first_fail_ts(first_fail_ts)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;

  int          m_pcnt [NCH];
  int          m_fcnt [NCH];
  bit          m_once [NCH];
  bit          m_pend [NCH];
  int unsigned m_dl   [NCH];
  bit [NCH-1:0] m_sticky, m_pp, m_fp, m_trigq;
  bit          m_ffv;
  int          m_ffch;
  int unsigned m_ts, m_ffts;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pcnt[i] = 0; m_fcnt[i] = 0; m_once[i] = 0; m_pend[i] = 0; m_dl[i] = 0;
    end
    m_sticky = '0; m_pp = '0; m_fp = '0; m_trigq = '0;
    m_ffv = 0; m_ffch = 0; m_ts = 0; m_ffts = 0;
  endtask

  // One sample of the reference: ROSE windows tracked as absolute deadlines.
  task automatic model_step();
    bit [NCH-1:0] rise, pp, fp;
    int m, w;
    rise = trig & ~m_trigq;
    pp = '0; fp = '0;
    for (int i = 0; i < NCH; i++) begin
      m = int'(mode[2*i +: 2]);
      w = int'(win[WIN_W*i +: WIN_W]);
      if (m == 3) begin
        if (m_pend[i]) begin
          if (cond[i]) begin pp[i] = 1; m_pend[i] = 0; end
          else if (m_ts == m_dl[i]) begin fp[i] = 1; m_pend[i] = 0; end
        end else if (rise[i]) begin
          if (cond[i]) pp[i] = 1;
          else if (w == 0) fp[i] = 1;
          else begin m_pend[i] = 1; m_dl[i] = m_ts + w; end
        end
      end else begin
        m_pend[i] = 0;
        if (m == 1) begin pp[i] = cond[i]; fp[i] = !cond[i]; end
        else if (m == 2 && !m_once[i]) begin pp[i] = cond[i]; fp[i] = !cond[i]; m_once[i] = 1; end
      end
    end
    m_trigq = trig;
    if (clear) begin
      for (int i = 0; i < NCH; i++) begin
        m_pcnt[i] = 0; m_fcnt[i] = 0; m_once[i] = 0; m_pend[i] = 0;
      end
      m_sticky = '0; m_pp = '0; m_fp = '0; m_ffv = 0; m_ffch = 0; m_ffts = 0;
    end else begin
      m_pp = pp; m_fp = fp; m_sticky |= fp;
      for (int i = 0; i < NCH; i++) begin
        if (pp[i] && m_pcnt[i] < CMAX) m_pcnt[i]++;
        if (fp[i] && m_fcnt[i] < CMAX) m_fcnt[i]++;
      end
      if (!m_ffv && fp != '0) begin
        m_ffv = 1; m_ffts = m_ts;
        for (int i = NCH - 1; i >= 0; i--) if (fp[i]) m_ffch = i;
      end
    end
    m_ts++;
  endtask

  task automatic check_all();
    logic [CNT_W*NCH-1:0] epc, efc;
    for (int i = 0; i < NCH; i++) begin
      epc[CNT_W*i +: CNT_W] = CNT_W'(m_pcnt[i]);
      efc[CNT_W*i +: CNT_W] = CNT_W'(m_fcnt[i]);
    end
    chk("pass_pulse", 32'(pass_pulse), 32'(m_pp));
    chk("fail_pulse", 32'(fail_pulse), 32'(m_fp));
    chk("fail_sticky", 32'(fail_sticky), 32'(m_sticky));
    chk("pass_cnt", 32'(pass_cnt), 32'(epc));
    chk("fail_cnt", 32'(fail_cnt), 32'(efc));
    chk("ts", ts, m_ts);
    chk("first_fail_valid", 32'(first_fail_valid), 32'(m_ffv));
    chk("first_fail_ch", 32'(first_fail_ch), 32'(m_ffch));
    chk("first_fail_ts", first_fail_ts, m_ffts);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();

    // ONCE on ch1 failing at the first sample; ROSE win=0 on ch2 with trig high from reset.
    mode = 8'h38; win = '0; trig = 4'b0100; cond = 4'b0100;
    rst_n = 1'b1;
    tick();
    cond = 4'b0110;
    repeat (4) tick();
    chk("once_fail_cnt1", 32'(fail_cnt[7:4]), 32'd1);
    chk("once_pass_cnt1", 32'(pass_cnt[7:4]), 32'd0);
    chk("once_ff_ch", 32'(first_fail_ch), 32'd1);
    chk("once_ff_ts", first_fail_ts, 32'd0);
    chk("rose_w0_pass_cnt2", 32'(pass_cnt[11:8]), 32'd1);

    clear = 1'b1; tick(); clear = 1'b0;
    mode = '0; trig = '0; cond = '0;
    chk("clear_pass_cnt", 32'(pass_cnt), 32'd0);

    // ALWAYS on ch0, cond toggling every two samples.
    mode = 8'h01;
    for (int k = 0; k < 8; k++) begin
      cond = {3'b000, ((k / 2) % 2 == 0)};
      tick();
    end
    chk("always_pass_cnt0", 32'(pass_cnt[3:0]), 32'd4);
    chk("always_fail_cnt0", 32'(fail_cnt[3:0]), 32'd4);
    chk("always_sticky0", 32'(fail_sticky[0]), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;

    // ROSE on ch2, win=3: pass after two samples, then a timeout with an ignored re-rise.
    mode = 8'h30; win = 16'h0300; trig = '0; cond = '0;
    tick();
    trig = 4'b0100; tick();
    trig = 4'b0000; tick();
    cond = 4'b0100; tick();
    cond = 4'b0000; tick();
    chk("rose_pass_cnt2", 32'(pass_cnt[11:8]), 32'd1);
    trig = 4'b0100; tick();
    trig = 4'b0000; tick();
    trig = 4'b0100; tick();
    trig = 4'b0000; tick();
    chk("rose_timeout_pulse", 32'(fail_pulse), 32'b0100);
    tick(); tick();
    chk("rose_fail_cnt2", 32'(fail_cnt[11:8]), 32'd1);
    chk("rose_pass_cnt2_b", 32'(pass_cnt[11:8]), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;

    // Simultaneous fails on ch1/ch3, then a later ch0 fail.
    mode = 8'h55; cond = 4'hF; tick();
    cond = 4'b0101; tick();
    chk("simul_ff_ch", 32'(first_fail_ch), 32'd1);
    cond = 4'b1110; tick();
    chk("later_ff_ch", 32'(first_fail_ch), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("clear_ff_valid", 32'(first_fail_valid), 32'd0);

    // Saturation at 15.
    mode = 8'h01; cond = '0;
    repeat (20) tick();
    chk("sat_fail_cnt0", 32'(fail_cnt[3:0]), 32'd15);

    // Reset during a pending ROSE window.
    mode = 8'h30; win = 16'h0500; trig = '0; cond = '0;
    tick();
    trig = 4'b0100; tick();
    trig = 4'b0000; tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) tick();

    // Random traffic with occasional mode/window changes and clears.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 15) == 0) win = 16'($urandom);
      trig  = 4'($urandom);
      cond  = 4'($urandom & $urandom & $urandom);
      clear = ($urandom_range(0, 24) == 0);
      tick();
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prop_monitor.md
Name: prop_monitor

Overview:
- Synthesisable, multi-channel property checker; successor to our single-signal assertion experiments.
- Each channel evaluates a boolean condition in one of three runtime-selectable modes:
  - ALWAYS: multiple evaluation, checked every clock.
  - ONCE: single evaluation, checked at the first clock only.
  - ROSE: rising-edge-triggered implication with a bounded response window.
- Sits beside DUT logic in emulation/FPGA builds. Reports pass/fail pulses, saturating counters, sticky flags and first-failure capture to a debug register block.

Parameters:
- NCH, 4, number of independent channels.
- WIN_W, 4, width of per-channel response window (0..2^WIN_W-1 cycles).
- CNT_W, 16, width of per-channel pass/fail counters.
- TS_W, 32, width of free-running timestamp.

Ports:
- clk  in  1  clock; all sampling on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of verdict state (see Behaviour).
- mode  in  2*NCH  per-channel mode: 0 OFF, 1 ALWAYS, 2 ONCE, 3 ROSE.
- win  in  WIN_W*NCH  per-channel ROSE window length.
- trig  in  NCH  per-channel antecedent (ROSE only).
- cond  in  NCH  per-channel consequent/condition.
- pass_pulse  out  NCH  one-cycle pass verdict.
- fail_pulse  out  NCH  one-cycle fail verdict.
- fail_sticky  out  NCH  set on any fail, held until clear/reset.
- pass_cnt  out  CNT_W*NCH  saturating pass counts.
- fail_cnt  out  CNT_W*NCH  saturating fail counts.
- ts  out  TS_W  free-running cycle timestamp.
- first_fail_valid  out  1  first failure captured.
- first_fail_ch  out  $clog2(NCH) (min 1)  channel of first failure.
- first_fail_ts  out  TS_W  ts value at first failure's deciding sample.

Behaviour:
- Reset (rst_n=0, async): all outputs 0. trig_q=0, once_done=0, all channels IDLE. ts=0.
- ts: increments every cycle after reset; wraps modulo 2^TS_W; never affected by clear.
- Verdict latency: the deciding sample is at edge k. pass_pulse/fail_pulse are high for the cycle following edge k. Counters, sticky flags and first-fail fields update on that same edge.
- trig_q: registers trig every cycle in all modes. rise = trig & ~trig_q. Because trig_q resets to 0, trig=1 at the first sample after reset counts as a rise.
- OFF: no evaluation; any pending ROSE window is aborted with no verdict.
- ALWAYS: every sample gives pass if cond=1, else fail.
- ONCE:
  - At the first sample with mode=ONCE and once_done=0: verdict on cond, then once_done=1.
  - No further verdicts until reset/clear.
  - once_done is not cleared by mode changes.
- ROSE: per-channel FSM IDLE/WAIT with window counter wc.
  - IDLE, no rise: nothing. Vacuous cycles produce no verdict and no count.
  - IDLE, rise & cond: pass, stay IDLE.
  - IDLE, rise & ~cond & win=0: fail, stay IDLE.
  - IDLE, rise & ~cond & win>0: go to WAIT, wc=1.
  - WAIT, cond: pass, go to IDLE.
  - WAIT, ~cond & wc==win: fail, go to IDLE.
  - WAIT, ~cond otherwise: wc++.
  - A rise while in WAIT is ignored (non-overlapping).
  - win is sampled at the rise; later changes to win do not affect the pending window.
  - A mode change away from ROSE while in WAIT aborts the window with no verdict.
- Counters: increment on each verdict; saturate at 2^CNT_W-1; never wrap.
- first_fail:
  - Captured on the first fail after reset/clear; frozen until the next clear.
  - If several channels fail on the same edge, the lowest index wins.
- clear=1:
  - Zeroes counters, fail_sticky, first_fail_*, once_done and pulses; returns FSMs to IDLE.
  - Verdicts that would have resolved on the clear edge are discarded.
  - trig_q still updates.
- Reset asserted mid-window: immediate return to reset state; no verdict emitted.

Test Plan:
- ALWAYS, ch0, cond toggling every 2 cycles for 8 cycles -> pass_cnt[0]=4, fail_cnt[0]=4, fail_sticky[0]=1. Each pulse appears one cycle after its sample.
- ONCE, ch1, cond=0 at first sample then held 1 -> exactly one fail_pulse. fail_cnt[1]=1, pass_cnt[1]=0. first_fail_ch=1, first_fail_ts=0.
- ROSE, ch2, win=3:
  - Rise at ts=10, cond high at ts=12 -> single pass at ts=12 verdict.
  - Rise at ts=20, cond never high -> fail decided at ts=23.
  - Extra rise at ts=21 -> ignored.
- ROSE, win=0: trig held high from reset with cond=1 -> one pass at the first sample (rise from reset). No further verdicts while trig stays high; vacuous cycles not counted.
- Simultaneous fails on ch3 and ch1 at ts=5 (ALWAYS) -> first_fail_ch=1, first_fail_ts=5. A later fail on ch0 does not overwrite the capture. After clear, all counters and flags read 0.
- Saturation, CNT_W=4: 20 consecutive ALWAYS fails -> fail_cnt=15. Then assert rst_n low during a ROSE WAIT -> all outputs 0 asynchronously, with no pulse after release.
